dda_axis_sched: RTL
===================

// Module: dda_axis_sched
// PURPOSE
//  Per-control-period scheduler for two dda pulse-generator channels (X, Y).
//  - Buffers step commands from the host or MCU bus in a small FIFO.
//  - On every control-period tick, pops one command, clamps it and loads both dda channels with a WR strobe.
//  - Reports underrun, late-load and clamp errors through sticky flags.
// PARAMETERS
//  PERIOD_CLKS  20000  clocks per control period (1 ms at 20 MHz)
//  WR_CLKS      2      WR strobe width in clocks (>=1)
//  DEPTH        8      command FIFO depth (power of 2)
//  NMAX1        49     max steps per period per axis; larger magnitudes are clamped
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  enable     in   1   1 = run period ticks; 0 = hold in IDLE
//  cmd_data   in   16  {Y[7:0], X[7:0]}; bit7 = dir, bits6:0 = step count
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   FIFO can accept (= !full)
//  wr         out  1   load strobe to both dda channels
//  n_x, n_y   out  8   dda N inputs, held stable while wr is high and afterwards
//  busy_x/_y  in   1   dda busy flags
//  fifo_level out  4   current FIFO occupancy, 0..DEPTH
//  running    out  1   state != IDLE
//  err_under  out  1   sticky: tick occurred with FIFO empty
//  err_late   out  1   sticky: tick occurred while busy_x or busy_y was still high
//  err_clamp  out  1   sticky: a step count was clamped
//  err_clr    in   1   clears all sticky flags (lower priority than a same-cycle set)
// BEHAVIOUR
//  - Reset values: all outputs 0, FIFO empty, period counter 0, state IDLE.
//    cmd_ready becomes 1 the cycle after rst deasserts.
//  - Reset mid-operation: wr drops in the same cycle rst is sampled, FIFO is flushed,
//    n_x/n_y are cleared to 0.
//  - Push: a command is written when cmd_valid && cmd_ready.
//    When full, cmd_ready=0 even if a pop happens in the same cycle.
//    A push and a pop in the same cycle on a non-full, non-empty FIFO leave the level unchanged.
//  - Period counter: counts 0..PERIOD_CLKS-1 and wraps; tick = (cnt == PERIOD_CLKS-1).
//    The counter runs only while enable=1 and resets to 0 whenever enable=0.
//  - FSM:
//    - IDLE -> WAIT: on enable=1.
//    - WAIT -> LOAD: on tick.
//      - FIFO non-empty: pop one command into n_x/n_y.
//      - FIFO empty: load {dir held, 0} on both axes and set err_under.
//      - busy_x | busy_y sampled high at tick: set err_late. The load proceeds anyway.
//    - LOAD: wr=1 for exactly WR_CLKS cycles, then -> RUN.
//    - RUN -> WAIT: immediately; the next tick starts the next load.
//    - Any state -> IDLE: on enable=0, aborting a wr pulse in progress.
//  - Latency: n_x/n_y change in the cycle after the tick, in the same cycle wr rises.
//  - Clamp: if cmd[6:0] > NMAX1, drive NMAX1 and keep the dir bit; set err_clamp.
//    Magnitudes 0..NMAX1 pass through unchanged.
//  - Sticky flags: set has priority over err_clr in the same cycle.
// CONFIGURATION
//  - Macro DDA_POS_TRACK_EN:
//    - Defined: adds ports pos_x and pos_y (out, signed 24-bit).
//      On each load, add the signed step count (dir=1 -> negative), after the clamp.
//      Accumulation wraps in two's complement; rst clears both to 0.
//    - Undefined: the ports and the accumulators are absent; all other behaviour is identical.
// STRUCTURE
//  - Package dda_pkg: NMAX1 and step-width constants, command field offsets (DIR_BIT, MAG_MSB),
//    FSM state encoding (IDLE, WAIT, LOAD, RUN).
//  - Sub-module dda_cmd_fifo: synchronous FIFO, DEPTH x 16.
//    Ports: clk, rst, push, din, pop, dout, full, empty, level.
//  - The top level holds the period counter, FSM, clamp logic, flags and the optional position tracker.
// TESTING
//  - Push X=0x05, Y=0x83, enable=1: at the first tick, wr is high for 2 clocks,
//    n_x=0x05, n_y=0x83; fifo_level goes 1->0.
//  - Enable with the FIFO empty: at the tick, n_x=n_y=0x00 with dir held,
//    err_under=1 and stays set until err_clr.
//  - Push X=0x7F (127): n_x=0x31 (49), err_clamp=1.
//    Push X=0xB1 (dir=1, 49): n_x=0xB1, no clamp.
//  - Fill 8 commands: cmd_ready=0 and a 9th push is ignored.
//    At the next tick, level goes 8->7 and cmd_ready=1 the following cycle.
//  - Hold busy_x=1 across a tick: err_late=1 and the load still occurs.
//    Assert rst during wr: wr=0 in that cycle, level=0, n_x=n_y=0.
//  - With DDA_POS_TRACK_EN: loads of +10, -3 (0x83), +49 give pos_x=56.

Source files
------------

// File: rtl/dda_pkg.sv
// Shared constants, command layout and FSM encoding for the dda scheduler.
// Optional position tracking in the top is enabled by DDA_POS_TRACK_EN.
package dda_pkg;

  localparam int NMAX1   = 49;
  localparam int STEP_W  = 8;
  localparam int DIR_BIT = 7;
  localparam int MAG_MSB = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LOAD,
    RUN
  } state_t;

  typedef struct packed {
    logic [STEP_W-1:0] y;
    logic [STEP_W-1:0] x;
  } cmd_t;

  function automatic logic step_over(input logic [STEP_W-1:0] c);
    return c[MAG_MSB:0] > 7'(NMAX1);
  endfunction

  function automatic logic [STEP_W-1:0] clamp_step(
    input logic [STEP_W-1:0] c
  );
    if (step_over(c)) return {c[DIR_BIT], 7'(NMAX1)};
    return c;
  endfunction

endpackage

// File: rtl/dda_cmd_fifo.sv
// Synchronous command FIFO with occupancy count.
// Pushes while full and pops while empty are ignored.
module dda_cmd_fifo
  import dda_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rp];
  assign level  = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/dda_axis_sched.sv
// Per-period X/Y dda load scheduler with command FIFO and sticky errors.
// DDA_POS_TRACK_EN adds signed 24-bit position outputs pos_x/pos_y.
module dda_axis_sched
  import dda_pkg::*;
#(
  parameter int PERIOD_CLKS = 20000,
  parameter int WR_CLKS     = 2,
  parameter int DEPTH       = 8,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              wr,
  output logic [STEP_W-1:0] n_x,
  output logic [STEP_W-1:0] n_y,
  input  logic              busy_x,
  input  logic              busy_y,
  output logic [LW-1:0]     fifo_level,
  output logic              running,
  output logic              err_under,
  output logic              err_late,
  output logic              err_clamp,
  input  logic              err_clr
`ifdef DDA_POS_TRACK_EN
  ,
  output logic signed [23:0] pos_x,
  output logic signed [23:0] pos_y
`endif
);

  localparam int CW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam int WW = $clog2(WR_CLKS + 1);

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [WW-1:0]     r_wcnt;
  logic              r_rdy_en;
  logic [STEP_W-1:0] r_nx;
  logic [STEP_W-1:0] r_ny;
  logic              r_eu;
  logic              r_el;
  logic              r_ec;

  logic              w_tick;
  logic              w_load;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [15:0]       w_dout;
  cmd_t              w_cmd;
  logic [STEP_W-1:0] w_cx;
  logic [STEP_W-1:0] w_cy;
  logic              w_clamp;

  assign w_tick    = (r_cnt == CW'(PERIOD_CLKS - 1));
  assign w_load    = enable && (r_state == WAIT) && w_tick;
  assign w_pop     = w_load && !w_empty;
  assign cmd_ready = r_rdy_en && !w_full;
  assign w_push    = cmd_valid && cmd_ready;

  assign w_cmd   = cmd_t'(w_dout);
  assign w_cx    = clamp_step(w_cmd.x);
  assign w_cy    = clamp_step(w_cmd.y);
  assign w_clamp = w_pop && (step_over(w_cmd.x) || step_over(w_cmd.y));

  // Gated combinationally so reset or disable cuts a pulse immediately
  assign wr        = (r_state == LOAD) && enable && !rst;
  assign running   = (r_state != IDLE);
  assign n_x       = r_nx;
  assign n_y       = r_ny;
  assign err_under = r_eu;
  assign err_late  = r_el;
  assign err_clamp = r_ec;

  dda_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (cmd_data),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) r_rdy_en <= 1'b0;
    else     r_rdy_en <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) r_cnt <= '0;
    else if (w_tick)    r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: w_next = WAIT;
        WAIT: if (w_tick) w_next = LOAD;
        LOAD: if (r_wcnt == WW'(WR_CLKS - 1)) w_next = RUN;
        RUN:  w_next = WAIT;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != LOAD) r_wcnt <= '0;
    else                        r_wcnt <= r_wcnt + 1'b1;
  end

  // An empty-FIFO load keeps each axis direction with zero steps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nx <= '0;
      r_ny <= '0;
    end else if (w_pop) begin
      r_nx <= w_cx;
      r_ny <= w_cy;
    end else if (w_load) begin
      r_nx <= {r_nx[DIR_BIT], 7'd0};
      r_ny <= {r_ny[DIR_BIT], 7'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_eu <= 1'b0;
      r_el <= 1'b0;
      r_ec <= 1'b0;
    end else begin
      r_eu <= (w_load && w_empty) || (r_eu && !err_clr);
      r_el <= (w_load && (busy_x || busy_y)) || (r_el && !err_clr);
      r_ec <= w_clamp || (r_ec && !err_clr);
    end
  end

`ifdef DDA_POS_TRACK_EN
  function automatic logic signed [23:0] step_val(
    input logic [STEP_W-1:0] s
  );
    logic signed [23:0] m;
    m = 24'(s[MAG_MSB:0]);
    return s[DIR_BIT] ? -m : m;
  endfunction

  logic signed [23:0] r_px;
  logic signed [23:0] r_py;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px <= '0;
      r_py <= '0;
    end else if (w_pop) begin
      r_px <= r_px + step_val(w_cx);
      r_py <= r_py + step_val(w_cy);
    end
  end

  assign pos_x = r_px;
  assign pos_y = r_py;
`else
  // Position tracking is not built in this configuration
`endif

endmodule
